ps2_kbd_feeder: RTL and testbench
=================================

Name: ps2_kbd_feeder

Overview:
- Receives PS/2 scan-set-2 frames from the keyboard and decodes make/break/extended sequences with shift/caps state.
- Translates key presses to ASCII and pushes them into the 8-entry keyboard queue in the memory subsystem using the `we_fifo`/`datain_fifo`/`count` write interface.
- Sits directly upstream of the queue and the write-pointer register.
- `clk` is the same clock as the memory write clock (`wrclk`).

Parameters:
- TIMEOUT_CYCLES, 50000: idle clk cycles between PS/2 falling edges before a partial frame is aborted.
- PTR_W, 3: queue pointer width; queue depth is 2^PTR_W.

Ports:
- clk  in  1  system clock, same net as memory write clock.
- clrn  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- r_ptr  in  PTR_W  queue read pointer, low bits of pointer register 0.
- we_fifo  out  1  one-cycle queue write strobe.
- datain_fifo  out  8  ASCII byte to write.
- count  out  PTR_W  next write pointer, valid with we_fifo.
- overflow  out  1  sticky: a key was dropped because the queue was full.
- frame_err  out  1  one-cycle pulse on a parity, stop-bit or timeout error.
- caps_lock  out  1  current caps-lock state.
- last_scan  out  8  last valid scan byte received.

Behaviour:
- Reset (clrn=0, async):
  - All outputs 0.
  - Internal w_ptr=0; shift, caps, brk and ext flags 0.
  - Receiver returns to IDLE. A reset mid-frame discards the partial frame.
- Synchroniser: 3-flop chain on ps2_clk and ps2_data. A falling edge is sync[2]=1 and sync[1]=0. Data is sampled from sync[1] in the edge cycle.
- Receiver FSM:
  - IDLE: on an edge with data=0 go to DATA, bitcnt=0. Data=1 is a bad start bit: stay in IDLE, no error.
  - DATA: shift bits in LSB first; after the 8th bit go to PARITY.
  - PARITY: latch the bit, go to STOP.
  - STOP: go to IDLE on the edge. The frame is good when the XOR of 8 data bits and the parity bit is 1 (odd parity) and the stop bit is 1.
    - Good frame: scan_valid pulses in the next cycle and last_scan is updated.
    - Bad frame: frame_err pulses; no scan_valid.
  - Timeout: in any state other than IDLE, if TIMEOUT_CYCLES cycles pass with no edge, return to IDLE, pulse frame_err, and discard the byte.
- Decoder, evaluated on scan_valid:
  - 0xF0: set brk.
  - 0xE0: set ext.
  - Any other code with brk=1: if 0x12 or 0x59 (and ext=0), clear shift. Emit nothing, then clear brk and ext.
  - Make code:
    - 0x12 or 0x59: set shift.
    - 0x58: toggle caps.
    - Otherwise look up ASCII; on a non-zero result, raise an internal request with the registered ASCII. Then clear ext.
  - Repeated make codes from typematic repeat each emit a character.
- ASCII table, make codes:
  - Letters map to 'a'..'z'. Uppercase when shift XOR caps.
  - Main-row digits: 0x45,16,1E,26,25,2E,36,3D,3E,46 map to '0'..'9'.
  - Shifted digits: 0x3E gives '*', 0x46 gives '(', 0x45 gives ')'. Other shifted digits give the digit.
  - 0x55 gives '=' unshifted, '+' shifted. 0x4E gives '-'. 0x49 gives '.'. 0x4A gives '/'. 0x29 gives 0x20. 0x5A gives 0x0A. 0x66 gives 0x08.
  - Keypad digits: 0x70,69,72,7A,6B,73,74,6C,75,7D map to '0'..'9'.
  - Keypad operators: 0x79 '+', 0x7B '-', 0x7C '*', 0x71 '.'.
  - Extended: E0 4A gives '/', E0 5A gives 0x0A. All other extended codes are ignored. All unlisted codes give 0 and no request.
- Write stage:
  - Stop-bit edge in cycle E, scan_valid in E+1, request in E+2. we_fifo is asserted in E+3 for exactly one cycle.
  - With the strobe, datain_fifo=ASCII and count=(w_ptr+1) mod 2^PTR_W; w_ptr is updated to count on the same edge.
  - Full is (w_ptr+1)==r_ptr, evaluated with the r_ptr present in the request cycle. When full: no strobe, w_ptr unchanged, overflow set to 1 and held until reset.
  - datain_fifo and count hold their last values between strobes.
- Wrap: w_ptr 7 advances to count 0.
- caps_lock = caps flag.

Test Plan:
- Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) with r_ptr=0: we_fifo pulses once at E+3, datain_fifo=0x61, count=1.
- Sequence 12, 1C, F0 1C, F0 12, 1C: writes 0x41 then 0x61; count=1 then 2.
- Frame 0x1C with wrong parity: frame_err pulse, no we_fifo, last_scan unchanged.
- r_ptr=0, send 8 presses of 0x16: seven writes with count 1..7; the 8th is dropped with overflow=1. Then r_ptr=3 and one more press: write with count=0.
- Sequence 58, F0 58, 21: caps_lock=1, writes 0x43. Sequence E0 5A gives 0x0A; E0 75 gives no write.
- Start bit plus 4 data bits, then silence for TIMEOUT_CYCLES: frame_err pulses and the next full 0x45 frame writes 0x30. clrn pulse mid-frame: all outputs 0 and count restarts at 1.

Source files
------------

// File: rtl/ps2_kbd_feeder_if.sv
// Keyboard queue write interface.
// master (feeder): drives we_fifo, datain_fifo, count; reads r_ptr.
// slave (queue):   reads we_fifo, datain_fifo, count; drives r_ptr.
//   we_fifo     - one-cycle write strobe
//   datain_fifo - ASCII byte to write
//   count       - next write pointer, valid with we_fifo
//   r_ptr       - queue read pointer
interface ps2_kbd_feeder_if #(
  parameter int unsigned PTR_W = 3
) ();
  logic             we_fifo;
  logic [7:0]       datain_fifo;
  logic [PTR_W-1:0] count;
  logic [PTR_W-1:0] r_ptr;

  modport master (
    output we_fifo,
    output datain_fifo,
    output count,
    input  r_ptr
  );

  modport slave (
    input  we_fifo,
    input  datain_fifo,
    input  count,
    output r_ptr
  );
endinterface

// File: rtl/ps2_kbd_feeder.sv
// PS/2 keyboard receiver and ASCII feeder for the keyboard queue.
// Receives scan-set-2 frames, tracks shift/caps/break/extended state, translates
// make codes to ASCII and writes them into the queue via q_if.
//   clk       - system clock (same net as the queue write clock)
//   clrn      - asynchronous active-low reset
//   ps2_clk   - raw PS/2 clock (asynchronous)
//   ps2_data  - raw PS/2 data (asynchronous)
//   q_if      - queue write port (we_fifo, datain_fifo, count out; r_ptr in)
//   overflow  - sticky, a key was dropped because the queue was full
//   frame_err - one-cycle pulse on parity, stop-bit or timeout error
//   caps_lock - current caps-lock state
//   last_scan - last valid scan byte received
module ps2_kbd_feeder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned PTR_W          = 3
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic                    ps2_clk,
  input  logic                    ps2_data,
  ps2_kbd_feeder_if.master        q_if,
  output logic                    overflow,
  output logic                    frame_err,
  output logic                    caps_lock,
  output logic [7:0]              last_scan
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  // Make code to ASCII; zero means "no character".
  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic ext,
                                          input logic shift, input logic caps);
    logic [7:0] r;
    r = 8'h00;
    if (ext) begin
      case (code)
        8'h4A:   r = "/";
        8'h5A:   r = 8'h0A;
        default: r = 8'h00;
      endcase
    end else begin
      case (code)
        8'h1C: r = "a";  8'h32: r = "b";  8'h21: r = "c";  8'h23: r = "d";
        8'h24: r = "e";  8'h2B: r = "f";  8'h34: r = "g";  8'h33: r = "h";
        8'h43: r = "i";  8'h3B: r = "j";  8'h42: r = "k";  8'h4B: r = "l";
        8'h3A: r = "m";  8'h31: r = "n";  8'h44: r = "o";  8'h4D: r = "p";
        8'h15: r = "q";  8'h2D: r = "r";  8'h1B: r = "s";  8'h2C: r = "t";
        8'h3C: r = "u";  8'h2A: r = "v";  8'h1D: r = "w";  8'h22: r = "x";
        8'h35: r = "y";  8'h1A: r = "z";
        8'h45: r = shift ? ")" : "0";
        8'h16: r = "1";  8'h1E: r = "2";  8'h26: r = "3";  8'h25: r = "4";
        8'h2E: r = "5";  8'h36: r = "6";  8'h3D: r = "7";
        8'h3E: r = shift ? "*" : "8";
        8'h46: r = shift ? "(" : "9";
        8'h55: r = shift ? "+" : "=";
        8'h4E: r = "-";  8'h49: r = ".";  8'h4A: r = "/";
        8'h29: r = 8'h20; 8'h5A: r = 8'h0A; 8'h66: r = 8'h08;
        8'h70: r = "0";  8'h69: r = "1";  8'h72: r = "2";  8'h7A: r = "3";
        8'h6B: r = "4";  8'h73: r = "5";  8'h74: r = "6";  8'h6C: r = "7";
        8'h75: r = "8";  8'h7D: r = "9";
        8'h79: r = "+";  8'h7B: r = "-";  8'h7C: r = "*";  8'h71: r = ".";
        default: r = 8'h00;
      endcase
      if (r >= "a" && r <= "z" && (shift ^ caps)) r = r - 8'h20;
    end
    return r;
  endfunction

  // Receiver
  logic [2:0]       sync_clk_q, sync_clk_d;
  logic [2:0]       sync_dat_q, sync_dat_d;
  rx_state_e        state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             scan_valid_q, scan_valid_d;
  logic [7:0]       last_scan_q, last_scan_d;
  logic             ferr_q, ferr_d;
  // Decoder
  logic             shift_q, shift_d;
  logic             caps_q, caps_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic             req_q, req_d;
  logic [7:0]       ascii_q, ascii_d;
  // Write stage; w_ptr doubles as the count output since they only change together
  logic             we_q, we_d;
  logic [7:0]       din_q, din_d;
  logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
  logic             ovf_q, ovf_d;

  logic             fall;
  logic             bit_in;
  logic [7:0]       lut;
  logic [PTR_W-1:0] w_nxt;
  logic             unused_dat;

  assign fall       = sync_clk_q[2] & ~sync_clk_q[1];
  assign bit_in     = sync_dat_q[1];
  assign unused_dat = sync_dat_q[2];
  assign w_nxt      = w_ptr_q + PTR_W'(1);
  assign lut        = ascii_of(last_scan_q, ext_q, shift_q, caps_q);

  always_comb begin
    sync_clk_d   = {sync_clk_q[1:0], ps2_clk};
    sync_dat_d   = {sync_dat_q[1:0], ps2_data};
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    tmo_d        = tmo_q;
    scan_valid_d = 1'b0;
    last_scan_d  = last_scan_q;
    ferr_d       = 1'b0;
    shift_d      = shift_q;
    caps_d       = caps_q;
    brk_d        = brk_q;
    ext_d        = ext_q;
    req_d        = 1'b0;
    ascii_d      = ascii_q;
    we_d         = 1'b0;
    din_d        = din_q;
    w_ptr_d      = w_ptr_q;
    ovf_d        = ovf_q;

    // Receiver
    case (state_q)
      StIdle: begin
        // A high start bit is treated as line noise and silently ignored.
        if (fall && !bit_in) begin
          state_d  = StData;
          bitcnt_d = 3'd0;
        end
      end
      StData: begin
        if (fall) begin
          shreg_d  = {bit_in, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = bit_in;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          if ((^{shreg_q, par_q}) && bit_in) begin
            scan_valid_d = 1'b1;
            last_scan_d  = shreg_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort a stalled partial frame.
    if (state_q == StIdle) begin
      tmo_d = '0;
    end else if (fall) begin
      tmo_d = '0;
    end else if (tmo_q == TmoLast) begin
      tmo_d   = '0;
      state_d = StIdle;
      ferr_d  = 1'b1;
    end else begin
      tmo_d = tmo_q + TmoW'(1);
    end

    // Decoder
    if (scan_valid_q) begin
      if (last_scan_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (last_scan_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (brk_q) begin
        if ((last_scan_q == 8'h12 || last_scan_q == 8'h59) && !ext_q) shift_d = 1'b0;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        ext_d = 1'b0;
        if (last_scan_q == 8'h12 || last_scan_q == 8'h59) begin
          shift_d = 1'b1;
        end else if (last_scan_q == 8'h58) begin
          caps_d = ~caps_q;
        end else if (lut != 8'h00) begin
          req_d   = 1'b1;
          ascii_d = lut;
        end
      end
    end

    // Write stage; full uses r_ptr as seen in the request cycle.
    if (req_q) begin
      if (w_nxt == q_if.r_ptr) begin
        ovf_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        din_d   = ascii_q;
        w_ptr_d = w_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_clk_q   <= '0;
      sync_dat_q   <= '0;
      state_q      <= StIdle;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      scan_valid_q <= 1'b0;
      last_scan_q  <= '0;
      ferr_q       <= 1'b0;
      shift_q      <= 1'b0;
      caps_q       <= 1'b0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      req_q        <= 1'b0;
      ascii_q      <= '0;
      we_q         <= 1'b0;
      din_q        <= '0;
      w_ptr_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      sync_clk_q   <= sync_clk_d;
      sync_dat_q   <= sync_dat_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      scan_valid_q <= scan_valid_d;
      last_scan_q  <= last_scan_d;
      ferr_q       <= ferr_d;
      shift_q      <= shift_d;
      caps_q       <= caps_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      req_q        <= req_d;
      ascii_q      <= ascii_d;
      we_q         <= we_d;
      din_q        <= din_d;
      w_ptr_q      <= w_ptr_d;
      ovf_q        <= ovf_d;
    end
  end

  assign q_if.we_fifo     = we_q;
  assign q_if.datain_fifo = din_q;
  assign q_if.count       = w_ptr_q;
  assign overflow         = ovf_q;
  assign frame_err        = ferr_q;
  assign caps_lock        = caps_q;
  assign last_scan        = last_scan_q;

endmodule

// File: tb/tb_ps2_kbd_feeder.sv
// Randomised and directed bench for ps2_kbd_feeder against a table-driven keyboard model.
module tb_ps2_kbd_feeder;

  localparam int unsigned TO = 300;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       overflow, frame_err, caps_lock;
  logic [7:0] last_scan;

  ps2_kbd_feeder_if #(.PTR_W(3)) q_if ();

  ps2_kbd_feeder #(.TIMEOUT_CYCLES(TO), .PTR_W(3)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .q_if      (q_if),
    .overflow  (overflow),
    .frame_err (frame_err),
    .caps_lock (caps_lock),
    .last_scan (last_scan)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed writes and frame errors
  logic [7:0]  obs_data[$];
  logic [2:0]  obs_cnt[$];
  int unsigned obs_cyc[$];
  int          ferr_seen = 0;

  always @(negedge clk) begin
    if (q_if.we_fifo === 1'b1) begin
      obs_data.push_back(q_if.datain_fifo);
      obs_cnt.push_back(q_if.count);
      obs_cyc.push_back(cyc);
    end
    if (frame_err === 1'b1) ferr_seen <= ferr_seen + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: lookup tables plus keyboard state
  logic [7:0] tbl_plain[256];
  logic [7:0] tbl_shift[256];
  bit         is_letter[256];
  logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
  logic [7:0] digit_codes[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
  logic [7:0] pad_codes[10]    = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C,
                                   8'h75, 8'h7D};

  task automatic build_tables();
    for (int i = 0; i < 256; i++) begin
      tbl_plain[i] = 8'h00; tbl_shift[i] = 8'h00; is_letter[i] = 1'b0;
    end
    for (int i = 0; i < 26; i++) begin
      tbl_plain[letter_codes[i]] = 8'(8'h61 + i);
      tbl_shift[letter_codes[i]] = 8'(8'h41 + i);
      is_letter[letter_codes[i]] = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      tbl_plain[digit_codes[i]] = 8'(8'h30 + i);
      tbl_shift[digit_codes[i]] = 8'(8'h30 + i);
      tbl_plain[pad_codes[i]]   = 8'(8'h30 + i);
      tbl_shift[pad_codes[i]]   = 8'(8'h30 + i);
    end
    tbl_shift[8'h3E] = "*"; tbl_shift[8'h46] = "("; tbl_shift[8'h45] = ")";
    tbl_plain[8'h55] = "="; tbl_shift[8'h55] = "+";
    tbl_plain[8'h4E] = "-"; tbl_plain[8'h49] = "."; tbl_plain[8'h4A] = "/";
    tbl_plain[8'h29] = 8'h20; tbl_plain[8'h5A] = 8'h0A; tbl_plain[8'h66] = 8'h08;
    tbl_plain[8'h79] = "+"; tbl_plain[8'h7B] = "-"; tbl_plain[8'h7C] = "*";
    tbl_plain[8'h71] = ".";
    foreach (tbl_plain[i]) if (i != 8'h55 && !is_letter[i] && tbl_shift[i] == 8'h00)
      tbl_shift[i] = tbl_plain[i];
  endtask

  bit         m_shift, m_caps, m_brk, m_ext, m_ovf;
  int         m_wptr;
  logic [7:0] m_last;
  logic [7:0] exp_data[$];
  logic [2:0] exp_cnt[$];
  int         exp_ferr = 0;
  int unsigned fall_cyc = 0;

  function automatic logic [7:0] ascii_ref(input logic [7:0] code);
    if (m_ext) return (code == 8'h4A) ? 8'h2F : (code == 8'h5A) ? 8'h0A : 8'h00;
    if (is_letter[code]) return (m_shift ^ m_caps) ? tbl_shift[code] : tbl_plain[code];
    return m_shift ? tbl_shift[code] : tbl_plain[code];
  endfunction

  task automatic model_reset();
    m_shift = 0; m_caps = 0; m_brk = 0; m_ext = 0; m_ovf = 0; m_wptr = 0; m_last = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] code);
    logic [7:0] a;
    m_last = code;
    if (code == 8'hF0) m_brk = 1;
    else if (code == 8'hE0) m_ext = 1;
    else if (m_brk) begin
      if ((code == 8'h12 || code == 8'h59) && !m_ext) m_shift = 0;
      m_brk = 0; m_ext = 0;
    end else begin
      if (code == 8'h12 || code == 8'h59) m_shift = 1;
      else if (code == 8'h58) m_caps = !m_caps;
      else begin
        a = ascii_ref(code);
        if (a != 8'h00) begin
          if ((m_wptr + 1) % 8 == int'(q_if.r_ptr)) m_ovf = 1;
          else begin
            m_wptr = (m_wptr + 1) % 8;
            exp_data.push_back(a);
            exp_cnt.push_back(3'(m_wptr));
          end
        end
      end
      m_ext = 0;
    end
  endtask

  // PS/2 line driving
  task automatic ps2_bit(input logic b);
    @(posedge clk); #1; ps2_data = b;
    repeat (H) @(posedge clk);
    #1; ps2_clk = 1'b0; fall_cyc = cyc;
    repeat (H) @(posedge clk);
    #1; ps2_clk = 1'b1;
  endtask

  task automatic send_raw(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) ps2_bit(bits[i]);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit good);
    logic par;
    par = good ? ~^code : ^code;
    send_raw({1'b1, par, code, 1'b0}, 11);
    repeat (12) @(posedge clk);
    if (!good) exp_ferr++;
  endtask

  task automatic press(input logic [7:0] code);
    send_frame(code, 1'b1);
    model_byte(code);
  endtask

  task automatic compare_group(input string tag);
    int n;
    check({tag, ".n_writes"}, obs_data.size(), exp_data.size());
    n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.data[%0d]", tag, i), obs_data[i], exp_data[i]);
      check($sformatf("%s.count[%0d]", tag, i), obs_cnt[i], exp_cnt[i]);
    end
    check({tag, ".overflow"}, overflow, m_ovf);
    check({tag, ".caps_lock"}, caps_lock, m_caps);
    check({tag, ".last_scan"}, last_scan, m_last);
    check({tag, ".frame_errs"}, ferr_seen, exp_ferr);
    obs_data.delete(); obs_cnt.delete(); obs_cyc.delete();
    exp_data.delete(); exp_cnt.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".we_fifo"}, q_if.we_fifo, 1'b0);
    check({tag, ".datain"}, q_if.datain_fifo, 8'h00);
    check({tag, ".count"}, q_if.count, 3'd0);
    check({tag, ".overflow"}, overflow, 1'b0);
    check({tag, ".frame_err"}, frame_err, 1'b0);
    check({tag, ".caps_lock"}, caps_lock, 1'b0);
    check({tag, ".last_scan"}, last_scan, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #1; clrn = 1'b1;
    repeat (4) @(posedge clk);
    model_reset();
  endtask

  initial begin
    int ferr0;
    int waited;
    logic [7:0] code;
    build_tables();
    model_reset();
    q_if.r_ptr = 3'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    #1; clrn = 1'b1;
    repeat (4) @(posedge clk);

    // Single 'a' press, with pipeline latency from the stop-bit edge
    press(8'h1C);
    if (obs_cyc.size() > 0) check("t1.latency", obs_cyc[0] - fall_cyc, 32'd5);
    compare_group("t1");

    // Shifted and unshifted 'a'
    press(8'h12); press(8'h1C); press(8'hF0); press(8'h1C);
    press(8'hF0); press(8'h12); press(8'h1C);
    compare_group("t2");

    // Bad parity: error pulse, no write, last_scan kept
    send_frame(8'h1C, 1'b0);
    compare_group("t3");

    // Fill the queue to overflow, then free space by moving r_ptr
    do_reset();
    q_if.r_ptr = 3'd0;
    for (int i = 0; i < 8; i++) press(8'h16);
    compare_group("t4a");
    q_if.r_ptr = 3'd3;
    press(8'h16);
    compare_group("t4b");

    // Caps lock and extended codes
    press(8'h58); press(8'hF0); press(8'h58); press(8'h21);
    press(8'hE0); press(8'h5A); press(8'hE0); press(8'h75);
    press(8'hE0); press(8'h4A);
    compare_group("t5");

    // Partial frame then silence: timeout error, then a normal frame
    send_raw({1'b1, 1'b0, 8'h45, 1'b0}, 5);
    ferr0 = ferr_seen;
    waited = 0;
    while (ferr_seen == ferr0 && waited < int'(TO) + 100) begin
      @(posedge clk); waited++;
    end
    check("t6.timeout_err", ferr_seen, ferr0 + 1);
    exp_ferr++;
    repeat (4) @(posedge clk);
    press(8'h45);
    compare_group("t6");

    // Reset in the middle of a frame
    q_if.r_ptr = 3'd0;
    send_raw({1'b1, 1'b0, 8'h1C, 1'b0}, 4);
    @(posedge clk); #1; clrn = 1'b0;
    @(negedge clk);
    check_zero_outputs("t7.reset");
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (2) @(posedge clk);
    #1; clrn = 1'b1;
    repeat (4) @(posedge clk);
    model_reset();
    press(8'h1C);
    compare_group("t7");

    // Randomised key stream with occasional bad frames and reader movement
    for (int f = 0; f < 120; f++) begin
      if ($urandom_range(0, 7) == 0) q_if.r_ptr = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: code = letter_codes[$urandom_range(0, 25)];
        4:          code = ($urandom_range(0, 1) == 0) ? digit_codes[$urandom_range(0, 9)]
                                                       : pad_codes[$urandom_range(0, 9)];
        5:          code = 8'hF0;
        6:          code = 8'hE0;
        7:          code = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
        8:          code = 8'h58;
        default:    code = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 9) == 0) send_frame(code, 1'b0);
      else press(code);
      if (f % 20 == 19) compare_group($sformatf("rnd%0d", f / 20));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
